// File: rtl/booth_arbiter.sv
// Round-robin front end sharing one sequential Booth multiplier among NREQ requesters.
// A watchdog releases the multiplier if its ready never returns after a start.
module booth_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 12,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a,
    input  logic [NREQ*W-1:0] b,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   done,
    output logic [2*W-1:0]    result,
    output logic              err,
    output logic              busy,
    output logic              m_start,
    output logic [W-1:0]      m_multiplicand,
    output logic [W-1:0]      m_multiplier,
    input  logic              m_ready,
    input  logic [2*W-1:0]    m_prod
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   last_q, last_d;
    logic [NREQ-1:0] gnt_oh_q, gnt_oh_d;
    logic [CW-1:0]   wdog_q, wdog_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            start_q, start_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [2*W-1:0]  result_q, result_d;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_oh;
    logic [W-1:0]    pick_a, pick_b;

    // Search upward from the requester after the last one served, wrapping at NREQ.
    always_comb begin : rr_search
        int            idx;
        logic [IW-1:0] idx_v;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_oh    = '0;
        idx        = 0;
        idx_v      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_v = IW'(idx);
            if (!pick_found && req[idx_v]) begin
                pick_found = 1'b1;
                pick_idx   = idx_v;
            end
        end
        pick_oh[pick_idx] = pick_found;
    end

    always_comb begin : operand_mux
        pick_a = '0;
        pick_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) begin
                pick_a = a[i*W +: W];
                pick_b = b[i*W +: W];
            end
        end
    end

    always_comb begin : next_state
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_oh_d = gnt_oh_q;
        last_d   = last_q;
        wdog_d   = wdog_q;
        result_d = result_q;
        ack_d    = '0;
        done_d   = '0;
        err_d    = 1'b0;
        start_d  = 1'b0;
        mcand_d  = '0;
        mplier_d = '0;
        case (state_q)
            S_IDLE: begin
                // The multiplier is not reset with us, so a start waits for its ready.
                if (pick_found && m_ready) begin
                    state_d  = S_ISSUE;
                    gnt_d    = pick_idx;
                    gnt_oh_d = pick_oh;
                    ack_d    = pick_oh;
                    start_d  = 1'b1;
                    mcand_d  = pick_a;
                    mplier_d = pick_b;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                last_d  = gnt_q;
                wdog_d  = '0;
            end
            S_WAIT: begin
                if (m_ready) begin
                    result_d = m_prod;
                    done_d   = gnt_oh_q;
                    state_d  = S_IDLE;
                end else if (wdog_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            gnt_oh_q <= '0;
            last_q   <= IW'(NREQ - 1);
            wdog_q   <= '0;
            ack_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_oh_q <= gnt_oh_d;
            last_q   <= last_d;
            wdog_q   <= wdog_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            err_q    <= err_d;
            start_q  <= start_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
        end
    end

    assign ack            = ack_q;
    assign done           = done_q;
    assign err            = err_q;
    assign result         = result_q;
    assign busy           = (state_q != S_IDLE);
    assign m_start        = start_q;
    assign m_multiplicand = mcand_q;
    assign m_multiplier   = mplier_q;

endmodule

// File: tb/tb_booth_arbiter.sv
// Self-checking bench for booth_arbiter: behavioural multiplier, round-robin reference
// model and a scoreboard drained by an independent monitor.
module tb_booth_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 12;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] a = '0;
    logic [NREQ*W-1:0] b = '0;
    logic [NREQ-1:0]   ack, done;
    logic [2*W-1:0]    result;
    logic              err, busy, m_start;
    logic [W-1:0]      m_multiplicand, m_multiplier;
    logic              m_ready = 1'b1;
    logic [2*W-1:0]    m_prod = '0;

    booth_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b),
        .ack(ack), .done(done), .result(result), .err(err), .busy(busy),
        .m_start(m_start), .m_multiplicand(m_multiplicand), .m_multiplier(m_multiplier),
        .m_ready(m_ready), .m_prod(m_prod)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        int xi, yi;
        xi = $signed(x);
        yi = $signed(y);
        return (2*W)'(xi * yi);
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Behavioural multiplier: no reset, ready low for 6 cycles after a sampled start.
    int   mdl_cnt = 0;
    logic stall = 1'b0;
    logic [2*W-1:0] mdl_prod = '0;
    always @(posedge clk) begin
        if (m_start && m_ready && mdl_cnt == 0) begin
            mdl_cnt  <= 6;
            m_ready  <= 1'b0;
            m_prod   <= '0;
            mdl_prod <= ref_mul(m_multiplicand, m_multiplier);
        end else if (mdl_cnt != 0 && !stall) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) begin
                m_ready <= 1'b1;
                m_prod  <= mdl_prod;
            end
        end
    end

    typedef struct {
        int             idx;
        logic [2*W-1:0] prod;
        int             t_ack;
        bit             is_err;
    } exp_t;

    exp_t           sb[$];
    int             ref_last = NREQ - 1;
    logic [2*W-1:0] last_result = '0;
    int             cyc = 0;
    int             ack_cnt [NREQ] = '{default: 0};
    int             done_cnt[NREQ] = '{default: 0};
    int             err_cnt = 0;
    bit             rr_phase = 1'b0;
    int             prev_ack = -1;
    int             rr_acks = 0;

    // Monitor: predicts each grant from the request pattern, pops on done/err.
    initial begin
        exp_t            e;
        int              g;
        logic [NREQ-1:0] oh;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                cyc++;
                if (ack != '0) begin
                    g = rr_pick(req, ref_last);
                    check("ack_has_pending_req", (g >= 0), 1);
                    if (g >= 0) begin
                        oh = '0;
                        oh[g] = 1'b1;
                        check("ack_grant", ack, oh);
                        check("start_only_when_ready", m_ready, 1);
                        check("m_start_with_ack", m_start, 1);
                        check("m_multiplicand", m_multiplicand, a[g*W +: W]);
                        check("m_multiplier", m_multiplier, b[g*W +: W]);
                        check("busy_in_issue", busy, 1);
                        e.idx    = g;
                        e.prod   = ref_mul(a[g*W +: W], b[g*W +: W]);
                        e.t_ack  = cyc;
                        e.is_err = stall;
                        sb.push_back(e);
                        ref_last = g;
                        ack_cnt[g]++;
                        if (rr_phase) begin
                            if (prev_ack >= 0) check("rr_interval", cyc - prev_ack, 9);
                            prev_ack = cyc;
                            rr_acks++;
                        end
                    end
                end else begin
                    check("idle_mult_outputs", {m_start, m_multiplicand, m_multiplier}, 0);
                end
                if (done != '0 || err) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done_or_err", {done, err}, 0);
                    end else begin
                        e = sb.pop_front();
                        if (e.is_err) begin
                            err_cnt++;
                            check("err_pulse", err, 1);
                            check("no_done_on_abort", done, 0);
                            check("err_latency", cyc - e.t_ack, TIMEOUT + 1);
                            check("result_held_on_err", result, last_result);
                        end else begin
                            oh = '0;
                            oh[e.idx] = 1'b1;
                            done_cnt[e.idx]++;
                            check("done_onehot", done, oh);
                            check("no_err_on_done", err, 0);
                            check("result", result, e.prod);
                            check("done_latency", cyc - e.t_ack, 8);
                            last_result = e.prod;
                        end
                        check("busy_after_finish", busy, 0);
                    end
                end
            end
        end
    end

    task automatic set_ops(input int i, input logic [W-1:0] av, input logic [W-1:0] bv);
        a[i*W +: W] = av;
        b[i*W +: W] = bv;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        @(negedge clk);
        while (!(!busy && m_ready && sb.size() == 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) check("idle_timeout", 0, 1);
    endtask

    // Raise req[i] and hold it until the matching ack is seen.
    task automatic request(input int i);
        int n;
        n = 0;
        @(negedge clk);
        req[i] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[i] && n < 60);
        if (n >= 60) check("ack_timeout", 0, 1);
        req[i] = 1'b0;
    endtask

    task automatic run_one(input int i, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [2*W-1:0] exp_res, input string name);
        wait_idle(100);
        set_ops(i, av, bv);
        request(i);
        wait_idle(100);
        check(name, result, exp_res);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int n, a3, d3, d1;

        repeat (3) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_m_start", m_start, 0);
        check("rst_result", result, 0);
        rst_n = 1'b1;

        // Single requester 0: ack one cycle after the sampling edge.
        @(negedge clk);
        set_ops(0, -12'sd3, 12'sd5);
        req[0] = 1'b1;
        @(posedge clk);
        #1;
        check("ack0_first", ack, 4'b0001);
        @(negedge clk);
        req[0] = 1'b0;
        wait_idle(100);
        check("neg3_times_5", result, 24'hFFFFF1);

        run_one(2, 12'sd2047, -12'sd2048, 24'hC00800, "max_times_min");
        run_one(2, -12'sd2048, -12'sd2048, 24'h400000, "min_times_min");
        run_one(2, 12'sd0, -12'sd1, 24'h000000, "zero_times_neg1");

        // All requesters held from reset: strict rotation, one grant per 9 cycles.
        wait_idle(100);
        rst_n = 1'b0;
        sb.delete();
        ref_last = NREQ - 1;
        last_result = '0;
        for (int i = 0; i < NREQ; i++) set_ops(i, W'($urandom), W'($urandom));
        rr_phase = 1'b1;
        prev_ack = -1;
        rr_acks = 0;
        @(negedge clk);
        req = '1;
        rst_n = 1'b1;
        n = 0;
        while (rr_acks < 8 && n < 150) begin
            @(negedge clk);
            n++;
        end
        if (n >= 150) check("rr_timeout", 0, 1);
        req = '0;
        rr_phase = 1'b0;
        wait_idle(100);

        // Reset while the multiplier is mid-run.
        set_ops(1, 12'sd100, -12'sd7);
        request(1);
        repeat (4) @(negedge clk);
        check("busy_in_wait", busy, 1);
        rst_n = 1'b0;
        sb.delete();
        ref_last = NREQ - 1;
        last_result = '0;
        #1;
        check("midrst_ack", ack, 0);
        check("midrst_done", done, 0);
        check("midrst_busy", busy, 0);
        check("midrst_result", result, 0);
        @(negedge clk);
        set_ops(1, -12'sd77, 12'sd33);
        req[1] = 1'b1;
        rst_n = 1'b1;
        check("mult_still_running", m_ready, 0);
        n = 0;
        while (!ack[1] && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("post_rst_ack_timeout", 0, 1);
        req[1] = 1'b0;
        wait_idle(100);
        check("post_rst_product", result, ref_mul(-12'sd77, 12'sd33));

        // Multiplier never returns ready: watchdog abort, then normal service.
        wait_idle(100);
        stall = 1'b1;
        set_ops(0, W'($urandom), W'($urandom));
        n = err_cnt;
        request(0);
        a3 = 0;
        while (err_cnt == n && a3 < 60) begin
            @(negedge clk);
            a3++;
        end
        if (a3 >= 60) check("err_timeout", 0, 1);
        stall = 1'b0;
        run_one(2, 12'sd5, 12'sd6, 24'd30, "served_after_abort");

        // req[3] pulsed while requester 1 is in flight is never served.
        wait_idle(100);
        a3 = ack_cnt[3];
        d3 = done_cnt[3];
        d1 = done_cnt[1];
        set_ops(1, W'($urandom), W'($urandom));
        request(1);
        repeat (2) @(negedge clk);
        req[3] = 1'b1;
        @(negedge clk);
        req[3] = 1'b0;
        wait_idle(100);
        repeat (3) @(negedge clk);
        check("dropped_req3_no_ack", ack_cnt[3], a3);
        check("dropped_req3_no_done", done_cnt[3], d3);
        check("req1_done_once", done_cnt[1], d1 + 1);

        // Random request traffic against the round-robin reference.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && ack[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 5) == 0) begin
                    set_ops(i, W'($urandom), W'($urandom));
                    req[i] = 1'b1;
                end
            end
        end
        @(negedge clk);
        req = '0;
        wait_idle(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
